// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-code bit positions,
// IO address map, FSM states and the load lane-extract/extend helper.
package dmem_pkg;

  localparam int EN_ST  = 0;
  localparam int EN_SB  = 1;
  localparam int EN_SH  = 2;
  localparam int EN_SW  = 3;
  localparam int EN_LB  = 4;
  localparam int EN_LH  = 5;
  localparam int EN_LBU = 6;
  localparam int EN_LHU = 7;
  localparam int EN_LW  = 8;

  localparam logic [31:0] ADDR_LEDR   = 32'h0000_7000;
  localparam logic [31:0] ADDR_LEDG   = 32'h0000_7010;
  localparam logic [31:0] ADDR_HEX_LO = 32'h0000_7020;
  localparam logic [31:0] ADDR_HEX_HI = 32'h0000_7024;
  localparam logic [31:0] ADDR_LCD    = 32'h0000_7030;
  localparam logic [31:0] ADDR_SW     = 32'h0000_7800;

  typedef enum logic {
    IDLE,
    DATA
  } state_e;

  typedef enum logic [2:0] {
    LD_B,
    LD_BU,
    LD_H,
    LD_HU,
    LD_W
  } ld_kind_e;

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input ld_kind_e    kind);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (kind)
      LD_B:    return {{24{b[7]}}, b};
      LD_BU:   return {24'h0, b};
      LD_H:    return {{16{h[15]}}, h};
      LD_HU:   return {16'h0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port data SRAM: synchronous read, byte-enabled write, no reset.
module dmem_sram #(
  parameter int DEPTH_WORDS = 2048
) (
  input  logic                           clk_i,
  input  logic                           en_i,
  input  logic [3:0]                     be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // An enabled cycle with no byte enables is a read.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      if (be_i == 4'b0000) rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder: decodes the one-hot access code, owns the
// data SRAM and memory-mapped IO, and stalls each load for one wait state.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 2048,
  parameter int SW_SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_st_data,
  input  logic [8:0]  req_mem_en,
  output logic        rsp_ready,
  output logic [31:0] rsp_ld_data,
  output logic        rsp_err,
  input  logic [31:0] io_sw,
  output logic [31:0] io_ledr,
  output logic [31:0] io_ledg,
  output logic [31:0] io_lcd,
  output logic [63:0] io_hex
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SRAM_BYTES = 32'(4 * DEPTH_WORDS);

  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  state_e   state_q, state_d;
  logic     err_q, err_d;
  ld_kind_e ld_kind_q, ld_kind_d;
  logic [1:0]  ld_lane_q, ld_lane_d;
  logic        ld_io_q, ld_io_d;
  logic        ld_bad_q, ld_bad_d;
  logic [31:0] io_rd_q, io_rd_d;
  logic [31:0] ld_hold_q, ld_hold_d;
  logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
  logic [63:0] hex_q, hex_d;
  logic [SW_SYNC_STAGES-1:0][31:0] sw_sync_q, sw_sync_d;

  logic [7:0]  acc_bits;
  logic        access, is_load, is_store_type, legal, misal, bad;
  logic        hit_sram, hit_ledr, hit_ledg, hit_hex_lo, hit_hex_hi, hit_lcd, hit_sw;
  logic [31:0] word_addr, io_word, st_wdata, sram_rdata, ld_now;
  logic [3:0]  st_be, sram_be;
  logic        sram_en;
  ld_kind_e    kind_dec;

  assign acc_bits      = req_mem_en[8:1];
  assign access        = |acc_bits;
  assign is_load       = |req_mem_en[8:4];
  assign is_store_type = |req_mem_en[3:1];
  assign legal = (acc_bits != 8'd0) && ((acc_bits & (acc_bits - 8'd1)) == 8'd0)
              && (req_mem_en[EN_ST] == is_store_type);
  assign misal = ((req_mem_en[EN_SH] | req_mem_en[EN_LH] | req_mem_en[EN_LHU]) & req_addr[0])
              | ((req_mem_en[EN_SW] | req_mem_en[EN_LW]) & (req_addr[1:0] != 2'b00));

  assign word_addr  = {req_addr[31:2], 2'b00};
  assign hit_sram   = req_addr < SRAM_BYTES;
  assign hit_ledr   = word_addr == ADDR_LEDR;
  assign hit_ledg   = word_addr == ADDR_LEDG;
  assign hit_hex_lo = word_addr == ADDR_HEX_LO;
  assign hit_hex_hi = word_addr == ADDR_HEX_HI;
  assign hit_lcd    = word_addr == ADDR_LCD;
  assign hit_sw     = word_addr == ADDR_SW;
  // The switch port is read-only, so any store that lands there is rejected.
  assign bad = !legal || misal
            || !(hit_sram | hit_ledr | hit_ledg | hit_hex_lo | hit_hex_hi | hit_lcd | hit_sw)
            || (!is_load && hit_sw);

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = req_st_data;
    if (req_mem_en[EN_SB]) begin
      st_be    = 4'b0001 << req_addr[1:0];
      st_wdata = {4{req_st_data[7:0]}};
    end else if (req_mem_en[EN_SH]) begin
      st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{req_st_data[15:0]}};
    end else if (req_mem_en[EN_SW]) begin
      st_be = 4'b1111;
    end
  end

  always_comb begin
    if (req_mem_en[EN_LB])       kind_dec = LD_B;
    else if (req_mem_en[EN_LBU]) kind_dec = LD_BU;
    else if (req_mem_en[EN_LH])  kind_dec = LD_H;
    else if (req_mem_en[EN_LHU]) kind_dec = LD_HU;
    else                         kind_dec = LD_W;
  end

  always_comb begin
    io_word = 32'h0;
    if (hit_ledr)   io_word = ledr_q;
    if (hit_ledg)   io_word = ledg_q;
    if (hit_hex_lo) io_word = hex_q[31:0];
    if (hit_hex_hi) io_word = hex_q[63:32];
    if (hit_lcd)    io_word = lcd_q;
    if (hit_sw)     io_word = sw_sync_q[SW_SYNC_STAGES-1];
  end

  assign ld_now = ld_bad_q ? 32'h0
                : lane_extract(ld_io_q ? io_rd_q : sram_rdata, ld_lane_q, ld_kind_q);

  always_comb begin
    state_d   = state_q;
    err_d     = 1'b0;
    rsp_ready = 1'b1;
    sram_en   = 1'b0;
    sram_be   = 4'b0000;
    ld_kind_d = ld_kind_q;
    ld_lane_d = ld_lane_q;
    ld_io_d   = ld_io_q;
    ld_bad_d  = ld_bad_q;
    io_rd_d   = io_rd_q;
    ld_hold_d = ld_hold_q;
    ledr_d    = ledr_q;
    ledg_d    = ledg_q;
    lcd_d     = lcd_q;
    hex_d     = hex_q;
    sw_sync_d[0] = io_sw;
    for (int i = 1; i < SW_SYNC_STAGES; i++) sw_sync_d[i] = sw_sync_q[i-1];
    case (state_q)
      IDLE: begin
        if (access) begin
          err_d = bad;
          if (is_load) begin
            rsp_ready = 1'b0;
            state_d   = DATA;
            sram_en   = hit_sram && !bad;
            ld_kind_d = kind_dec;
            ld_lane_d = req_addr[1:0];
            ld_io_d   = !hit_sram;
            ld_bad_d  = bad;
            io_rd_d   = io_word;
          end else if (!bad) begin
            sram_en = hit_sram;
            sram_be = hit_sram ? st_be : 4'b0000;
            if (hit_ledr)   ledr_d        = merge_be(ledr_q, st_wdata, st_be);
            if (hit_ledg)   ledg_d        = merge_be(ledg_q, st_wdata, st_be);
            if (hit_lcd)    lcd_d         = merge_be(lcd_q, st_wdata, st_be);
            if (hit_hex_lo) hex_d[31:0]   = merge_be(hex_q[31:0], st_wdata, st_be);
            if (hit_hex_hi) hex_d[63:32]  = merge_be(hex_q[63:32], st_wdata, st_be);
          end
        end
      end
      default: begin
        // The pipeline still holds the load request here; it is consumed, not re-issued.
        state_d   = IDLE;
        ld_hold_d = ld_now;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      ld_hold_q <= 32'h0;
      ledr_q    <= 32'h0;
      ledg_q    <= 32'h0;
      lcd_q     <= 32'h0;
      hex_q     <= 64'h0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      ld_hold_q <= ld_hold_d;
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      lcd_q     <= lcd_d;
      hex_q     <= hex_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  always_ff @(posedge clk_i) begin
    ld_kind_q <= ld_kind_d;
    ld_lane_q <= ld_lane_d;
    ld_io_q   <= ld_io_d;
    ld_bad_q  <= ld_bad_d;
    io_rd_q   <= io_rd_d;
  end

  dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk_i   (clk_i),
    .en_i    (sram_en && !rst_i),
    .be_i    (sram_be),
    .addr_i  (req_addr[AW+1:2]),
    .wdata_i (st_wdata),
    .rdata_o (sram_rdata)
  );

  assign rsp_ld_data = (state_q == DATA) ? ld_now : ld_hold_q;
  assign rsp_err     = err_q;
  assign io_ledr     = ledr_q;
  assign io_ledg     = ledg_q;
  assign io_lcd      = lcd_q;
  assign io_hex      = hex_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one request per cycle driven on the falling
// edge, outputs sampled 1 ns later against hand-computed values.
module tb_dmem_responder;

  localparam logic [8:0] NONE = 9'b0_0000_0000;
  localparam logic [8:0] SB   = 9'b0_0000_0011;
  localparam logic [8:0] SH   = 9'b0_0000_0101;
  localparam logic [8:0] SW   = 9'b0_0000_1001;
  localparam logic [8:0] LB   = 9'b0_0001_0000;
  localparam logic [8:0] LBU  = 9'b0_0100_0000;
  localparam logic [8:0] LHU  = 9'b0_1000_0000;
  localparam logic [8:0] LW   = 9'b1_0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] req_addr = '0, req_st_data = '0, io_sw = '0;
  logic [8:0]  req_mem_en = '0;
  logic        rsp_ready, rsp_err;
  logic [31:0] rsp_ld_data, io_ledr, io_ledg, io_lcd;
  logic [63:0] io_hex;

  int total = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  dmem_responder #(.DEPTH_WORDS(2048), .SW_SYNC_STAGES(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_addr    (req_addr),
    .req_st_data (req_st_data),
    .req_mem_en  (req_mem_en),
    .rsp_ready   (rsp_ready),
    .rsp_ld_data (rsp_ld_data),
    .rsp_err     (rsp_err),
    .io_sw       (io_sw),
    .io_ledr     (io_ledr),
    .io_ledg     (io_ledg),
    .io_lcd      (io_lcd),
    .io_hex      (io_hex)
  );

  task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] d,
                     input logic [8:0] en);
    @(negedge clk_i);
    rst_i       = r;
    req_addr    = a;
    req_st_data = d;
    req_mem_en  = en;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    cyc(1, 32'h0, 32'h0, NONE);
    cyc(1, 32'h0, 32'h0, NONE);
    chk("rst_ready", rsp_ready, 1);
    chk("rst_ld", rsp_ld_data, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_io", {io_ledr | io_ledg | io_lcd, 32'h0} | io_hex, 0);

    // word store then load: ready 1,0,1
    cyc(0, 32'h100, 32'hDEADBEEF, SW);  chk("sw_ready", rsp_ready, 1);
    cyc(0, 32'h100, 32'h0, LW);         chk("lw_wait", rsp_ready, 0);
                                        chk("sw_no_err", rsp_err, 0);
    cyc(0, 32'h100, 32'h0, LW);         chk("lw_ready", rsp_ready, 1);
                                        chk("lw_data", rsp_ld_data, 32'hDEADBEEF);
    cyc(0, 32'h0, 32'h0, NONE);         chk("ld_hold", rsp_ld_data, 32'hDEADBEEF);

    // byte store, signed/unsigned byte loads, neighbours intact
    cyc(0, 32'h101, 32'h0000_0080, SB);
    cyc(0, 32'h101, 32'h0, LB);         chk("lb_wait", rsp_ready, 0);
    cyc(0, 32'h101, 32'h0, LB);         chk("lb_data", rsp_ld_data, 32'hFFFF_FF80);
    cyc(0, 32'h101, 32'h0, LBU);
    cyc(0, 32'h101, 32'h0, LBU);        chk("lbu_data", rsp_ld_data, 32'h0000_0080);
    cyc(0, 32'h100, 32'h0, LW);
    cyc(0, 32'h100, 32'h0, LW);         chk("sb_lanes", rsp_ld_data, 32'hDEAD_80EF);

    // IO registers incl. sub-word stores
    cyc(0, 32'h7020, 32'hCAFE_5678, SW);
    cyc(0, 32'h7022, 32'hFFFF_1234, SH); chk("hex_sw", io_hex, 64'h0000_0000_CAFE_5678);
    cyc(0, 32'h7000, 32'h1111_1111, SW); chk("hex_sh", io_hex, 64'h0000_0000_1234_5678);
    cyc(0, 32'h7012, 32'h0000_00AB, SB); chk("ledr", io_ledr, 32'h1111_1111);
    cyc(0, 32'h7030, 32'h2222_2222, SW); chk("ledg_sb", io_ledg, 32'h00AB_0000);
    cyc(0, 32'h7022, 32'h0, LHU);       chk("lcd", io_lcd, 32'h2222_2222);
    cyc(0, 32'h7022, 32'h0, LHU);       chk("lhu_hex", rsp_ld_data, 32'h0000_1234);

    // misaligned load
    cyc(0, 32'h102, 32'h0, LW);         chk("mis_wait", rsp_ready, 0);
    cyc(0, 32'h102, 32'h0, LW);         chk("mis_err", rsp_err, 1);
                                        chk("mis_data", rsp_ld_data, 0);
    cyc(0, 32'h0, 32'h0, NONE);         chk("err_1cyc", rsp_err, 0);
    // misaligned store, then illegal lb+st_en
    cyc(0, 32'h101, 32'h0000_FFFF, SH); chk("missh_ready", rsp_ready, 1);
    cyc(0, 32'h100, 32'h0, 9'b0_0001_0001); chk("missh_err", rsp_err, 1);
                                        chk("ill_wait", rsp_ready, 0);
    cyc(0, 32'h100, 32'h0, 9'b0_0001_0001); chk("ill_err", rsp_err, 1);
                                        chk("ill_data", rsp_ld_data, 0);
    // store code without st_en is illegal and must not write
    cyc(0, 32'h100, 32'h0000_0055, 9'b0_0000_0010);
    cyc(0, 32'h100, 32'h0, LW);         chk("illst_err", rsp_err, 1);
    cyc(0, 32'h100, 32'h0, LW);         chk("no_write", rsp_ld_data, 32'hDEAD_80EF);

    // switch synchronizer and read-only switch port
    io_sw = 32'h0000_A5A5;
    cyc(0, 32'h7800, 32'h0, LW);
    cyc(0, 32'h7800, 32'h0, LW);        chk("sw_early", rsp_ld_data, 0);
    cyc(0, 32'h7800, 32'h0, LW);
    cyc(0, 32'h7800, 32'h0, LW);        chk("sw_sync", rsp_ld_data, 32'h0000_A5A5);
    cyc(0, 32'h7800, 32'h1, SW);
    cyc(0, 32'h7800, 32'h0, LW);        chk("swst_err", rsp_err, 1);
    cyc(0, 32'h7800, 32'h0, LW);        chk("swst_ign", rsp_ld_data, 32'h0000_A5A5);

    // unmapped and last SRAM word
    cyc(0, 32'h0000_4000, 32'h0, LW);
    cyc(0, 32'h0000_4000, 32'h0, LW);   chk("unmap_err", rsp_err, 1);
                                        chk("unmap_data", rsp_ld_data, 0);
    cyc(0, 32'h1FFC, 32'h1357_2468, SW);
    cyc(0, 32'h1FFC, 32'h0, LH_HACK());
    cyc(0, 32'h1FFC, 32'h0, LH_HACK()); chk("top_lh", rsp_ld_data, 32'h0000_2468);
    cyc(0, 32'h1FFE, 32'h0, LB);
    cyc(0, 32'h1FFE, 32'h0, LB);        chk("top_lb", rsp_ld_data, 32'h0000_0057);

    // reset while in DATA
    cyc(0, 32'h100, 32'h0, LW);         chk("rd_wait", rsp_ready, 0);
    cyc(1, 32'h100, 32'h0, LW);         chk("rd_data_st", rsp_ready, 1);
    cyc(0, 32'h0, 32'h0, NONE);         chk("rd_ready", rsp_ready, 1);
                                        chk("rd_ld0", rsp_ld_data, 0);
                                        chk("rd_err0", rsp_err, 0);
                                        chk("rd_io0", {io_ledr | io_ledg | io_lcd, 32'h0} | io_hex, 0);
    cyc(0, 32'h100, 32'h0, LW);         chk("rd_idle", rsp_ready, 0);
    cyc(0, 32'h100, 32'h0, LW);         chk("rd_reload", rsp_ld_data, 32'hDEAD_80EF);

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

  function automatic logic [8:0] LH_HACK();
    return 9'b0_0010_0000;
  endfunction

endmodule
